// File: rtl/dca_matrix_load2mreg_mbank_if.sv
// Row-load, matrix-register move and loadreg hand-off signals of the multi-bank row loader.
// The loader itself connects through the slave modport.
interface dca_matrix_load2mreg_mbank_if #(
  parameter int BW_ROW  = 32,
  parameter int BW_BANK = 1
);
  logic               load_tensor_row_wvalid;
  logic               load_tensor_row_wlast;
  logic [BW_ROW-1:0]  load_tensor_row_wdata;
  logic               load_tensor_row_wready;
  logic               mreg_move_wenable;
  logic [BW_BANK-1:0] mreg_move_wbank;
  logic [BW_ROW-1:0]  mreg_move_wdata_list1d;
  logic               loadreg_rready;
  logic [BW_BANK-1:0] loadreg_rbank;
  logic               loadreg_rrequest;

  modport slave (
    input  load_tensor_row_wvalid, load_tensor_row_wlast, load_tensor_row_wdata,
    output load_tensor_row_wready,
    output mreg_move_wenable, mreg_move_wbank, mreg_move_wdata_list1d,
    output loadreg_rready, loadreg_rbank,
    input  loadreg_rrequest
  );

  modport master (
    output load_tensor_row_wvalid, load_tensor_row_wlast, load_tensor_row_wdata,
    input  load_tensor_row_wready,
    input  mreg_move_wenable, mreg_move_wbank, mreg_move_wdata_list1d,
    input  loadreg_rready, loadreg_rbank,
    output loadreg_rrequest
  );
endinterface

// File: rtl/dca_matrix_load2mreg_mbank.sv
// Multi-bank matrix row loader: writes incoming tensor rows into NUM_BANK matrix registers,
// masking columns, zero-padding short matrices and draining over-long ones.
module dca_matrix_load2mreg_mbank #(
  parameter int MATRIX_SIZE_PARA = 4,
  parameter int TENSOR_PARA      = 0,
  parameter int NUM_BANK         = 2,
  localparam int MATRIX_NUM_ROW   = MATRIX_SIZE_PARA,
  localparam int MATRIX_NUM_COL   = MATRIX_SIZE_PARA,
  localparam int BW_TENSOR_SCALAR = 8 << TENSOR_PARA,
  localparam int BW_TENSOR_ROW    = BW_TENSOR_SCALAR * MATRIX_NUM_COL,
  localparam int BW_BANK          = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1,
  localparam int BW_NUM_COL       = $clog2(MATRIX_NUM_COL) + 1
) (
  input  logic                  clk,
  input  logic                  rstnn,
  input  logic                  clear,
  input  logic                  enable,
  output logic                  busy,
  input  logic [BW_NUM_COL-1:0] cfg_num_col,
  output logic                  overflow_error,
  dca_matrix_load2mreg_mbank_if.slave io
);

  localparam logic [BW_TENSOR_SCALAR-1:0] TENSOR_ZERO = '0;

  typedef enum logic [1:0] {LOAD, PAD, DRAIN} wstate_t;

  wstate_t                   state;
  logic [MATRIX_NUM_ROW-1:0] row_oh;
  logic [NUM_BANK-1:0]       full;
  logic [NUM_BANK-1:0]       full_nxt;
  logic [BW_BANK-1:0]        wr_bank;
  logic [BW_BANK-1:0]        rd_bank;
  logic [BW_NUM_COL-1:0]     col_hold;
  logic [BW_NUM_COL-1:0]     ncol;
  logic                      wready;
  logic                      accept;
  logic                      fill;
  logic                      rel;
  logic                      last_row;
  logic [MATRIX_NUM_ROW-1:0] row_rot;

  function automatic logic [BW_NUM_COL-1:0] eff_cols(input logic [BW_NUM_COL-1:0] n);
    if (n == '0 || n >= BW_NUM_COL'(MATRIX_NUM_COL))
      return BW_NUM_COL'(MATRIX_NUM_COL);
    return n;
  endfunction

  function automatic logic [BW_TENSOR_ROW-1:0] mask_row(input logic [BW_TENSOR_ROW-1:0] row,
                                                        input logic [BW_NUM_COL-1:0]    n);
    logic [BW_TENSOR_ROW-1:0] r;
    r = row;
    for (int i = 0; i < MATRIX_NUM_COL; i++)
      if (i >= int'(n)) r[BW_TENSOR_SCALAR*i +: BW_TENSOR_SCALAR] = TENSOR_ZERO;
    return r;
  endfunction

  function automatic logic [BW_BANK-1:0] inc_bank(input logic [BW_BANK-1:0] b);
    return (b == BW_BANK'(NUM_BANK - 1)) ? '0 : b + 1'b1;
  endfunction

  assign last_row = row_oh[MATRIX_NUM_ROW-1];
  assign row_rot  = {row_oh[MATRIX_NUM_ROW-2:0], row_oh[MATRIX_NUM_ROW-1]};

  // Row datapath and handshakes: combinational on registered state, gated by enable
  always_comb begin
    wready = enable & (((state == LOAD) & ~full[wr_bank]) | (state == DRAIN));
    accept = io.load_tensor_row_wvalid & wready;
    ncol   = row_oh[0] ? eff_cols(cfg_num_col) : col_hold;
    rel    = io.loadreg_rrequest & full[rd_bank] & enable;
    fill   = ((state == LOAD) & accept & io.load_tensor_row_wlast & last_row) |
             ((state == PAD) & enable & last_row) |
             ((state == DRAIN) & accept & io.load_tensor_row_wlast);
    full_nxt = full;
    if (fill) full_nxt[wr_bank] = 1'b1;
    if (rel)  full_nxt[rd_bank] = 1'b0;
  end

  assign io.load_tensor_row_wready = wready;
  assign io.mreg_move_wenable      = ((state == LOAD) & accept) | ((state == PAD) & enable);
  assign io.mreg_move_wbank        = wr_bank;
  assign io.mreg_move_wdata_list1d = (state == PAD) ? '0 : mask_row(io.load_tensor_row_wdata, ncol);
  assign io.loadreg_rready         = full[rd_bank];
  assign io.loadreg_rbank          = rd_bank;
  assign busy                      = (state != LOAD) | ~row_oh[0];

  // Write FSM, bank occupancy and read pointer
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state          <= LOAD;
      row_oh         <= MATRIX_NUM_ROW'(1);
      full           <= '0;
      wr_bank        <= '0;
      rd_bank        <= '0;
      overflow_error <= 1'b0;
    end else if (clear) begin
      state          <= LOAD;
      row_oh         <= MATRIX_NUM_ROW'(1);
      full           <= '0;
      wr_bank        <= '0;
      rd_bank        <= '0;
      overflow_error <= 1'b0;
    end else if (enable) begin
      full <= full_nxt;
      if (rel)  rd_bank <= inc_bank(rd_bank);
      if (fill) wr_bank <= inc_bank(wr_bank);
      case (state)
        LOAD: begin
          if (accept) begin
            if (last_row) begin
              row_oh <= MATRIX_NUM_ROW'(1);
              if (!io.load_tensor_row_wlast) state <= DRAIN;
            end else begin
              row_oh <= row_rot;
              if (io.load_tensor_row_wlast) state <= PAD;
            end
          end
        end
        PAD: begin
          if (last_row) begin
            row_oh <= MATRIX_NUM_ROW'(1);
            state  <= LOAD;
          end else begin
            row_oh <= row_rot;
          end
        end
        DRAIN: begin
          if (accept) begin
            overflow_error <= 1'b1;
            if (io.load_tensor_row_wlast) state <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Column count captured with the first row of each matrix; only read while row_oh[0]==0
  always_ff @(posedge clk) begin
    if (enable && accept && state == LOAD && row_oh[0])
      col_hold <= eff_cols(cfg_num_col);
  end

endmodule

// File: tb/tb_dca_matrix_load2mreg_mbank.sv
// Bench for the multi-bank row loader (4x4, 8-bit scalars, two banks): directed vector table
// followed by randomized traffic against a behavioural model.
module tb_dca_matrix_load2mreg_mbank;
  localparam int ROW = 4;
  localparam int COL = 4;
  localparam int NB  = 2;

  logic       clk = 1'b0;
  logic       rstnn;
  logic       clear;
  logic       enable;
  logic       busy;
  logic [2:0] cfg_num_col;
  logic       overflow_error;

  int checks = 0;
  int errors = 0;

  dca_matrix_load2mreg_mbank_if #(.BW_ROW(32), .BW_BANK(1)) bus ();

  dca_matrix_load2mreg_mbank #(.MATRIX_SIZE_PARA(4), .TENSOR_PARA(0), .NUM_BANK(NB)) dut (
    .clk(clk), .rstnn(rstnn), .clear(clear), .enable(enable), .busy(busy),
    .cfg_num_col(cfg_num_col), .overflow_error(overflow_error), .io(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v, l; logic [31:0] d; logic [2:0] cfg; logic rq, en, clr;
    logic x_wr, x_we, x_wb; logic [31:0] x_wd; logic x_rr, x_rb, x_busy, x_ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic l, logic [31:0] d, logic [2:0] cfg, logic rq,
                              logic en, logic clr, logic x_wr, logic x_we, logic x_wb,
                              logic [31:0] x_wd, logic x_rr, logic x_rb, logic x_busy,
                              logic x_ovf);
    vec_t t;
    t.v = v; t.l = l; t.d = d; t.cfg = cfg; t.rq = rq; t.en = en; t.clr = clr;
    t.x_wr = x_wr; t.x_we = x_we; t.x_wb = x_wb; t.x_wd = x_wd;
    t.x_rr = x_rr; t.x_rb = x_rb; t.x_busy = x_busy; t.x_ovf = x_ovf;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic l, input logic [31:0] d, input logic [2:0] cfg,
                       input logic rq, input logic en, input logic clr);
    bus.load_tensor_row_wvalid = v;
    bus.load_tensor_row_wlast  = l;
    bus.load_tensor_row_wdata  = d;
    bus.loadreg_rrequest       = rq;
    cfg_num_col = cfg;
    enable      = en;
    clear       = clr;
  endtask

  // Behavioural reference: rows counted as integers, banks as a flag array
  bit m_full[NB];
  int m_wr, m_rd, m_rx, m_pad, m_ncol;
  bit m_drain, m_ovf;

  task automatic model_reset();
    for (int i = 0; i < NB; i++) m_full[i] = 1'b0;
    m_wr = 0; m_rd = 0; m_rx = 0; m_pad = 0; m_ncol = COL; m_drain = 0; m_ovf = 0;
  endtask

  function automatic int eff(input logic [2:0] c);
    return (c == 0 || c >= COL) ? COL : int'(c);
  endfunction

  function automatic logic [31:0] masked(input logic [31:0] d, input int n);
    logic [31:0] r;
    r = d;
    for (int i = 0; i < COL; i++) if (i >= n) r[8*i +: 8] = 8'h00;
    return r;
  endfunction

  initial begin
    logic v, l, rq, en, clr, loading, e_wready, acc, e_wen, do_fill, rel;
    logic [31:0] d, e_wd;
    logic [2:0] cfg;
    int n;

    // inputs: v l data cfg rq en clr | expected: wready wen wbank wdata rready rbank busy ovf
    tbl.push_back(mk(0,0,32'h0,0,0,1,0,            1,0,0,32'h0,0,0,0,0));
    tbl.push_back(mk(1,0,32'h04030201,0,0,1,0,     1,1,0,32'h04030201,0,0,0,0));
    tbl.push_back(mk(1,0,32'h08070605,0,0,1,0,     1,1,0,32'h08070605,0,0,1,0));
    tbl.push_back(mk(1,0,32'h0c0b0a09,0,0,1,0,     1,1,0,32'h0c0b0a09,0,0,1,0));
    tbl.push_back(mk(1,1,32'h100f0e0d,0,0,1,0,     1,1,0,32'h100f0e0d,0,0,1,0));
    tbl.push_back(mk(0,0,32'h0,0,0,1,0,            1,0,0,32'h0,1,0,0,0));
    tbl.push_back(mk(1,0,32'h44332211,3,0,1,0,     1,1,1,32'h00332211,1,0,0,0));
    tbl.push_back(mk(1,0,32'h44332211,0,0,1,0,     1,1,1,32'h00332211,1,0,1,0));
    tbl.push_back(mk(1,0,32'h44332211,0,0,1,0,     1,1,1,32'h00332211,1,0,1,0));
    tbl.push_back(mk(1,1,32'h44332211,0,0,1,0,     1,1,1,32'h00332211,1,0,1,0));
    tbl.push_back(mk(1,0,32'hdeadbeef,0,0,1,0,     0,0,0,32'h0,1,0,0,0));
    tbl.push_back(mk(1,0,32'hdeadbeef,0,1,1,0,     0,0,0,32'h0,1,0,0,0));
    tbl.push_back(mk(1,0,32'ha1a2a3a4,0,0,1,0,     1,1,0,32'ha1a2a3a4,1,1,0,0));
    tbl.push_back(mk(1,1,32'hb1b2b3b4,0,0,1,0,     1,1,0,32'hb1b2b3b4,1,1,1,0));
    tbl.push_back(mk(1,0,32'hdeadbeef,0,0,1,0,     0,1,0,32'h0,1,1,1,0));
    tbl.push_back(mk(1,0,32'hdeadbeef,0,0,1,0,     0,1,0,32'h0,1,1,1,0));
    tbl.push_back(mk(0,0,32'h0,0,1,1,0,            0,0,0,32'h0,1,1,0,0));
    tbl.push_back(mk(0,0,32'h0,0,1,1,0,            1,0,0,32'h0,1,0,0,0));
    tbl.push_back(mk(0,0,32'h0,0,1,1,0,            1,0,0,32'h0,0,1,0,0));
    tbl.push_back(mk(1,0,32'hc1c1c1c1,0,0,1,0,     1,1,1,32'hc1c1c1c1,0,1,0,0));
    tbl.push_back(mk(1,0,32'hc2c2c2c2,0,0,1,0,     1,1,1,32'hc2c2c2c2,0,1,1,0));
    tbl.push_back(mk(1,0,32'hc3c3c3c3,0,0,1,0,     1,1,1,32'hc3c3c3c3,0,1,1,0));
    tbl.push_back(mk(1,0,32'hc4c4c4c4,0,0,1,0,     1,1,1,32'hc4c4c4c4,0,1,1,0));
    tbl.push_back(mk(1,0,32'hc5c5c5c5,0,0,1,0,     1,0,0,32'h0,0,1,1,0));
    tbl.push_back(mk(1,1,32'hc6c6c6c6,0,0,1,0,     1,0,0,32'h0,0,1,1,1));
    tbl.push_back(mk(0,0,32'h0,0,0,1,0,            1,0,0,32'h0,1,1,0,1));
    tbl.push_back(mk(1,0,32'hddccbbaa,2,0,1,0,     1,1,0,32'h0000bbaa,1,1,0,1));
    tbl.push_back(mk(1,0,32'h11223344,0,1,0,0,     0,0,0,32'h0,1,1,1,1));
    tbl.push_back(mk(1,0,32'h11223344,0,0,1,0,     1,1,0,32'h00003344,1,1,1,1));
    tbl.push_back(mk(1,1,32'h55667788,0,0,1,0,     1,1,0,32'h00007788,1,1,1,1));
    tbl.push_back(mk(0,0,32'h0,0,0,1,1,            0,1,0,32'h0,1,1,1,1));
    tbl.push_back(mk(0,0,32'h0,0,0,1,0,            1,0,0,32'h0,0,0,0,0));

    rstnn = 1'b0;
    drive(0, 0, 32'h0, 0, 0, 1, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstnn = 1'b1;

    foreach (tbl[i]) begin
      @(posedge clk);
      #2;
      drive(tbl[i].v, tbl[i].l, tbl[i].d, tbl[i].cfg, tbl[i].rq, tbl[i].en, tbl[i].clr);
      #2;
      chk($sformatf("vec%0d wready", i), 32'(bus.load_tensor_row_wready), 32'(tbl[i].x_wr));
      chk($sformatf("vec%0d wenable", i), 32'(bus.mreg_move_wenable), 32'(tbl[i].x_we));
      if (tbl[i].x_we) begin
        chk($sformatf("vec%0d wbank", i), 32'(bus.mreg_move_wbank), 32'(tbl[i].x_wb));
        chk($sformatf("vec%0d wdata", i), bus.mreg_move_wdata_list1d, tbl[i].x_wd);
      end
      chk($sformatf("vec%0d rready", i), 32'(bus.loadreg_rready), 32'(tbl[i].x_rr));
      chk($sformatf("vec%0d rbank", i), 32'(bus.loadreg_rbank), 32'(tbl[i].x_rb));
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(tbl[i].x_busy));
      chk($sformatf("vec%0d overflow", i), 32'(overflow_error), 32'(tbl[i].x_ovf));
    end

    // Randomized traffic; a clear first puts DUT and model in the same state
    @(posedge clk);
    #2;
    drive(0, 0, 32'h0, 0, 0, 1, 1);
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #2;
      v   = ($urandom % 5) != 0;
      l   = ($urandom % 4) == 0;
      d   = $urandom;
      cfg = 3'($urandom % 8);
      rq  = ($urandom % 3) == 0;
      en  = ($urandom % 10) != 0;
      clr = ($urandom % 250) == 0;
      drive(v, l, d, cfg, rq, en, clr);
      #2;
      loading  = !m_drain && m_pad == 0;
      e_wready = en && ((loading && !m_full[m_wr]) || m_drain);
      acc      = v && e_wready;
      n        = (m_rx == 0) ? eff(cfg) : m_ncol;
      e_wen    = (loading && acc) || (m_pad > 0 && en);
      e_wd     = (m_pad > 0) ? 32'h0 : masked(d, n);
      chk("rnd wready", 32'(bus.load_tensor_row_wready), 32'(e_wready));
      chk("rnd wenable", 32'(bus.mreg_move_wenable), 32'(e_wen));
      if (e_wen) begin
        chk("rnd wbank", 32'(bus.mreg_move_wbank), 32'(m_wr));
        chk("rnd wdata", bus.mreg_move_wdata_list1d, e_wd);
      end
      chk("rnd rready", 32'(bus.loadreg_rready), 32'(m_full[m_rd]));
      chk("rnd rbank", 32'(bus.loadreg_rbank), 32'(m_rd));
      chk("rnd busy", 32'(busy), 32'(m_drain || m_pad > 0 || m_rx > 0));
      chk("rnd overflow", 32'(overflow_error), 32'(m_ovf));

      if (clr) begin
        model_reset();
      end else if (en) begin
        rel     = rq && m_full[m_rd];
        do_fill = 1'b0;
        if (loading && acc) begin
          if (m_rx == 0) m_ncol = n;
          m_rx++;
          if (l) begin
            if (m_rx == ROW) do_fill = 1'b1;
            else m_pad = ROW - m_rx;
          end else if (m_rx == ROW) begin
            m_drain = 1'b1;
          end
        end else if (m_pad > 0) begin
          m_pad--;
          if (m_pad == 0) do_fill = 1'b1;
        end else if (m_drain && acc) begin
          m_ovf = 1'b1;
          if (l) begin
            m_drain = 1'b0;
            do_fill = 1'b1;
          end
        end
        if (rel) begin
          m_full[m_rd] = 1'b0;
          m_rd = (m_rd + 1) % NB;
        end
        if (do_fill) begin
          m_full[m_wr] = 1'b1;
          m_wr = (m_wr + 1) % NB;
          m_rx = 0;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
